// File: rtl/sym_serializer.sv
// sym_serializer: 8b/10b symbol serializer with running-disparity tracking.
// One holding register in front of a 10-bit shift register lets the encoder
// hand over the next symbol while the current one is still on the line, so
// back-to-back symbols leave the block with no gap bit.
// Optional: define SYM_SERIALIZER_DISP_CHECK_EN to build the sticky disp_err
// output and its disparity check logic.
module sym_serializer #(
  parameter int MSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] sym_in,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic       rd,
  output logic       ser_out,
  output logic       ser_valid,
  output logic       sym_start
`ifdef SYM_SERIALIZER_DISP_CHECK_EN
  ,
  output logic       disp_err
`endif
);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [9:0] sh_q, sh_d;
  logic       rd_q, rd_d;
  logic       ser_out_q, ser_out_d;
  logic       ser_valid_q, ser_valid_d;
  logic       sym_start_q, sym_start_d;
`ifdef SYM_SERIALIZER_DISP_CHECK_EN
  logic       disp_err_q, disp_err_d;
`endif

  logic       accept;
  logic       last_bit;
  logic       load;
  logic       take_direct;
  logic [9:0] load_sym;
  logic [3:0] ones;

  // Number of ones in a 10-bit symbol.
  function automatic logic [3:0] popcnt10(input logic [9:0] s);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 10; i++) n = n + {3'b000, s[i]};
    return n;
  endfunction

  // Bit that goes on the line next, given the remaining symbol bits.
  function automatic logic first_bit(input logic [9:0] s);
    return (MSB_FIRST != 0) ? s[9] : s[0];
  endfunction

  // Remaining bits once first_bit() has been sent.
  function automatic logic [9:0] shift_out(input logic [9:0] s);
    return (MSB_FIRST != 0) ? {s[8:0], 1'b0} : {1'b0, s[9:1]};
  endfunction

  // Handshake: the hold slot frees up on the last bit because it reloads the shifter that edge.
  always_comb begin
    last_bit  = (state_q == SHIFT) && (cnt_q == 4'd9);
    sym_ready = !hold_full_q || last_bit;
    accept    = sym_valid && sym_ready;
    ones      = popcnt10(sym_in);
  end

  // FSM next state, hold/shift register movement and registered line outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sh_d        = sh_q;
    ser_out_d   = 1'b0;
    ser_valid_d = 1'b0;
    sym_start_d = 1'b0;
    load        = 1'b0;
    take_direct = 1'b0;
    load_sym    = hold_q;

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          load        = 1'b1;
          hold_full_d = 1'b0;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != 4'd9) begin
          cnt_d       = cnt_q + 4'd1;
          ser_out_d   = first_bit(sh_q);
          sh_d        = shift_out(sh_q);
          ser_valid_d = 1'b1;
        end else if (hold_full_q) begin
          load        = 1'b1;
          hold_full_d = 1'b0;
        end else if (accept) begin
          // Nothing held: the incoming symbol goes straight to the shifter.
          load        = 1'b1;
          take_direct = 1'b1;
          load_sym    = sym_in;
        end else begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          sh_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A load puts the first bit on the line at the same edge.
    if (load) begin
      cnt_d       = 4'd0;
      ser_out_d   = first_bit(load_sym);
      sh_d        = shift_out(load_sym);
      ser_valid_d = 1'b1;
      sym_start_d = 1'b1;
    end

    // Held hand-off and new accept may coincide: hold empties and refills on one edge.
    if (accept && !take_direct) begin
      hold_d      = sym_in;
      hold_full_d = 1'b1;
    end
  end

  // Running disparity follows the accepted symbol's weight; balanced symbols keep it.
  always_comb begin
    rd_d = rd_q;
    if (accept) begin
      if (ones > 4'd5)      rd_d = 1'b1;
      else if (ones < 4'd5) rd_d = 1'b0;
    end
  end

`ifdef SYM_SERIALIZER_DISP_CHECK_EN
  // Sticky flag for symbols that are illegal for the current disparity.
  always_comb begin
    disp_err_d = disp_err_q;
    if (accept && ((ones < 4'd4) || (ones > 4'd6) ||
                   (!rd_q && ones == 4'd4) || (rd_q && ones == 4'd6)))
      disp_err_d = 1'b1;
  end
`endif

  // State and datapath registers; reset discards anything held or in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sh_q        <= '0;
      rd_q        <= 1'b0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      sym_start_q <= 1'b0;
`ifdef SYM_SERIALIZER_DISP_CHECK_EN
      disp_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sh_q        <= sh_d;
      rd_q        <= rd_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      sym_start_q <= sym_start_d;
`ifdef SYM_SERIALIZER_DISP_CHECK_EN
      disp_err_q  <= disp_err_d;
`endif
    end
  end

  assign rd        = rd_q;
  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign sym_start = sym_start_q;
`ifdef SYM_SERIALIZER_DISP_CHECK_EN
  assign disp_err  = disp_err_q;
`endif

endmodule

// File: tb/tb_sym_serializer.sv
// Bench for sym_serializer: queue-based line model plus literal spot checks.
module tb_sym_serializer;
  localparam bit MSB = 1'b1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] sym_in;
  logic       sym_valid;
  logic       sym_ready, rd, ser_out, ser_valid, sym_start;
`ifdef SYM_SERIALIZER_DISP_CHECK_EN
  logic       disp_err;
`endif

  sym_serializer #(.MSB_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .sym_in(sym_in), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .rd(rd), .ser_out(ser_out), .ser_valid(ser_valid),
    .sym_start(sym_start)
`ifdef SYM_SERIALIZER_DISP_CHECK_EN
    , .disp_err(disp_err)
`endif
  );

  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;

  // Model: bits still to appear on the line (front = bit on the line now), held symbols.
  bit         m_out[$];
  logic [9:0] m_held[$];
  logic       m_rd;
  logic       m_derr;

  // Line statistics for the directed tests.
  int vld_cycles, vld_runs;
  bit prev_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail(input string name);
    total++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic int ones(input logic [9:0] s);
    int n = 0;
    for (int i = 0; i < 10; i++) n += s[i];
    return n;
  endfunction

  function automatic bit m_ready();
    return (m_held.size() == 0) || (m_out.size() == 1);
  endfunction

  function automatic void push_sym(input logic [9:0] s);
    for (int i = 0; i < 10; i++) m_out.push_back(MSB ? s[9-i] : s[i]);
  endfunction

  function automatic void model_reset();
    m_out.delete();
    m_held.delete();
    m_rd   = 1'b0;
    m_derr = 1'b0;
  endfunction

  // One clock edge of the model, from the inputs presented before the edge.
  function automatic void model_edge(input logic v, input logic [9:0] s);
    bit acc, was_idle, used;
    int n;
    acc      = v && m_ready();
    was_idle = (m_out.size() == 0);
    used     = 1'b0;
    if (acc) begin
      n = ones(s);
      if (n < 4 || n > 6 || (!m_rd && n == 4) || (m_rd && n == 6)) m_derr = 1'b1;
      if (n > 5) m_rd = 1'b1;
      else if (n < 5) m_rd = 1'b0;
    end
    if (!was_idle) void'(m_out.pop_front());
    if (m_out.size() == 0) begin
      if (m_held.size() != 0) push_sym(m_held.pop_front());
      else if (!was_idle && acc) begin
        push_sym(s);
        used = 1'b1;
      end
    end
    if (acc && !used) m_held.push_back(s);
  endfunction

  // Per-cycle comparison of every output against the model.
  task automatic compare();
    check("sym_ready", sym_ready, m_ready());
    check("rd", rd, m_rd);
    check("ser_valid", ser_valid, m_out.size() != 0);
    if (m_out.size() != 0) begin
      check("ser_out", ser_out, m_out[0]);
      check("sym_start", sym_start, m_out.size() == 10);
    end else begin
      check("ser_out_idle", ser_out, 1'b0);
      check("sym_start_idle", sym_start, 1'b0);
    end
`ifdef SYM_SERIALIZER_DISP_CHECK_EN
    check("disp_err", disp_err, m_derr);
`endif
    if (ser_valid === 1'b1) begin
      vld_cycles++;
      if (!prev_v) vld_runs++;
    end
    prev_v = (ser_valid === 1'b1);
  endtask

  task automatic stats_clear();
    vld_cycles = 0;
    vld_runs   = 0;
    prev_v     = 1'b0;
  endtask

  task automatic step(input logic v, input logic [9:0] s);
    sym_valid = v;
    sym_in    = s;
    @(posedge clk);
    model_edge(v, s);
    @(negedge clk);
    compare();
  endtask

  // Hold sym_valid until the symbol is taken (bounded).
  task automatic send(input logic [9:0] s);
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      done = m_ready();
      step(1'b1, s);
    end
    if (!done) fail("send");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 10'($urandom_range(0, 1023)));
  endtask

  task automatic do_reset();
    sym_valid = 1'b0;
    sym_in    = '0;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      compare();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    logic [9:0] got;
    int         first, nb;
    bit         start_ok, found;

    rst_n = 1'b1;
    stats_clear();
    do_reset();
    check("reset_ser_valid", ser_valid, 1'b0);
    check("reset_rd", rd, 1'b0);
    check("reset_ready", sym_ready, 1'b1);

    // K28.1 RD-: rd flips, bits appear two cycles later MSB first.
    step(1'b1, 10'b001111_1001);
    check("k28_rd", rd, 1'b1);
    got = '0; first = -1; nb = 0; start_ok = 1'b0;
    for (int c = 0; c < 14; c++) begin
      step(1'b0, 10'($urandom_range(0, 1023)));
      if (ser_valid === 1'b1 && nb < 10) begin
        if (first < 0) begin
          first    = c;
          start_ok = (sym_start === 1'b1);
        end
        got = {got[8:0], ser_out};
        nb++;
      end
    end
    check("k28_bits", got, 10'b0011111001);
    check("k28_latency", first, 0);
    check("k28_start", start_ok, 1'b1);

    // Balanced symbol with rd=1 keeps rd.
    send(10'b000101_0111);
    check("bal_rd", rd, 1'b1);
`ifdef SYM_SERIALIZER_DISP_CHECK_EN
    check("bal_derr", disp_err, 1'b0);
`endif
    idle(14);

    // Two symbols with valid held: one contiguous 20-bit burst, rd 0->1->0.
    do_reset();
    stats_clear();
    send(10'b001111_1010);
    check("b2b_rd1", rd, 1'b1);
    send(10'b110000_0101);
    check("b2b_rd2", rd, 1'b0);
    idle(24);
    check("b2b_cycles", vld_cycles, 20);
    check("b2b_runs", vld_runs, 1);

    // Three symbols under stall: nothing lost or duplicated, no gap.
    stats_clear();
    send(10'b001111_1010);
    send(10'b110000_0101);
    send(10'b000101_0111);
    idle(34);
    check("stall_cycles", vld_cycles, 30);
    check("stall_runs", vld_runs, 1);

    // 4-ones symbol at rd=0: flagged, still serialized.
    stats_clear();
    send(10'b110000_0110);
`ifdef SYM_SERIALIZER_DISP_CHECK_EN
    check("derr_set", disp_err, 1'b1);
`endif
    idle(14);
    check("derr_sym_cycles", vld_cycles, 10);
`ifdef SYM_SERIALIZER_DISP_CHECK_EN
    check("derr_sticky", disp_err, 1'b1);
`endif

    // Reset mid-symbol (cnt==5) with a second symbol held.
    do_reset();
    send(10'b001111_1001);
    send(10'b110000_0101);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_out.size() == 5 && m_held.size() == 1) found = 1'b1;
      else step(1'b0, '0);
    end
    if (!found) fail("mid_reset_setup");
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_valid", ser_valid, 1'b0);
    check("mid_rst_rd", rd, 1'b0);
    check("mid_rst_ready", sym_ready, 1'b1);
    @(negedge clk);
    compare();
    rst_n = 1'b1;
    stats_clear();
    idle(15);
    check("mid_rst_no_bits", vld_cycles, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 6, 10'($urandom_range(0, 1023)));
    idle(25);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/sym_serializer.md
SYM_SERIALIZER -- requirements
Module: sym_serializer

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1; 1 = sym_in[9] (bit a) transmitted first, 0 = sym_in[0] first.
REQ-002 SHALL have port clk  input  1  single clock; every register is clocked on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port sym_in  input  10  encoded 8b/10b symbol, written abcdei_fghj.
REQ-005 SHALL have port sym_valid  input  1  sym_in is valid this cycle.
REQ-006 SHALL have port sym_ready  output  1  block accepts sym_in this cycle.
REQ-007 SHALL have port rd  output  1  running disparity driven to the encoder; 0 = RD-, 1 = RD+.
REQ-008 SHALL have port ser_out  output  1  serial line bit.
REQ-009 SHALL have port ser_valid  output  1  ser_out carries a symbol bit.
REQ-010 SHALL have port sym_start  output  1  pulse on the first bit of each symbol.
REQ-011 SHALL have port disp_err  output  1  sticky disparity error; present only with the macro in REQ-030.

Function
REQ-012 SHALL complete a handshake ("accept") on any cycle with sym_valid=1 and sym_ready=1.
REQ-013 SHALL hold a 1-entry holding register (hold_q, hold_full) and a 10-bit shift register with a 4-bit bit counter (0..9).
REQ-014 SHALL implement a two-state FSM: IDLE (nothing shifting) and SHIFT.
REQ-015 SHALL drive sym_ready = !hold_full || (state==SHIFT && cnt==9), or equivalently !hold_full whenever state==IDLE.
REQ-016 SHALL write an accepted symbol into hold_q the same edge, setting hold_full.
REQ-017 SHALL move IDLE->SHIFT when hold_full=1: load the shift register from hold_q, clear hold_full, set cnt=0.
REQ-018 SHALL set cnt=cnt+1 in SHIFT each cycle and shift one bit, ordered per MSB_FIRST.
REQ-019 SHALL at cnt==9 reload from hold_q if hold_full, or from sym_in if an accept occurs that cycle (cnt->0, stay SHIFT); otherwise go to IDLE. Back-to-back symbols SHALL have no gap bit.
REQ-020 SHALL have accept-to-first-bit latency of 2 cycles from IDLE (accept edge, then load edge; first bit is registered after load).
REQ-021 SHALL register ser_out, ser_valid and sym_start. ser_valid=1 exactly for the 10 bit-cycles of each symbol. In IDLE, ser_out=0 and ser_valid=0.
REQ-022 SHALL count ones(sym_in) on each accept. RD SHALL update on the accept edge: ones>5 -> rd=1; ones<5 -> rd=0; ones==5 -> rd unchanged.
REQ-023 SHALL apply the RD update in REQ-022 regardless of the disparity error in REQ-031. Symbols with ones<4 or ones>6 SHALL still be serialized.
REQ-024 SHALL ignore sym_in while sym_valid=0. rd SHALL change only on accept.
REQ-025 SHALL follow this for simultaneous events at cnt==9 with hold_full=1 and an accept on the same cycle: hold_q->shift register and sym_in->hold_q on the same edge.

Reset
REQ-026 SHALL on rst_n=0, asynchronously force: state=IDLE, cnt=0, hold_full=0, shift register=0, rd=0, ser_out=0, ser_valid=0, sym_start=0, disp_err=0.
REQ-027 SHALL drive sym_ready=1 in the first cycle after reset release.
REQ-028 SHALL discard any partially shifted and any held symbol on reset mid-operation. Reset SHALL produce no partial output after release.
REQ-029 SHALL begin reset release from RD-, so the first symbol after reset is encoded with rd=0.

Configuration
REQ-030 SHALL include disp_err and its logic only when macro SYM_SERIALIZER_DISP_CHECK_EN is defined. Without it, the port SHALL be absent and no check logic SHALL be built.
REQ-031 SHALL with SYM_SERIALIZER_DISP_CHECK_EN defined, set disp_err=1 on the edge after an accept where:
- ones not in {4,5,6}, or
- rd=0 and ones==4, or
- rd=1 and ones==6.
disp_err SHALL then stay 1 until reset.

Verification
REQ-032 SHALL cover: reset, then accept 10'b001111_1001 (K28.1 RD-) -> rd=1 after the accept edge; after 2 cycles ser_out serially = 0,0,1,1,1,1,1,0,0,1 with sym_start on the first bit.
REQ-033 SHALL cover: sym_valid held 1 with 10'b001111_1010 then 10'b110000_0101 -> 20 contiguous ser_valid cycles, no gap; rd sequence 0->1->0.
REQ-034 SHALL cover: stall, with sym_valid=1 continuously for 3 symbols -> sym_ready deasserts while hold_full and shifting, pulsing 1 only at cnt==9; no symbol lost or duplicated.
REQ-035 SHALL cover: accept a balanced symbol 10'b000101_0111 with rd=1 -> rd stays 1; with the macro defined, disp_err stays 0.
REQ-036 SHALL cover, with the macro defined: with rd=0, accept 10'b110000_0110 (4 ones) -> disp_err=1 next edge and sticky; the symbol is still serialized.
REQ-037 SHALL cover: assert rst_n=0 at cnt==5 with hold_full=1 -> ser_valid=0 immediately, no further bits after release, rd=0, sym_ready=1.
